// File: rtl/muldiv_seq_if.sv
// muldiv_seq_if -- pipeline <-> multiply/divide sequencer bundle.
//
// master modport (execute stage drives):
//   start, op[1:0], rs_val, rt_val  : operation request and operands
//   flush                           : cancel an in-flight operation
//   hi_we, lo_we, wdata             : MTHI / MTLO writes
// slave modport (sequencer drives):
//   busy, done, div_zero, op_err    : status
//   hi, lo                          : architectural HI/LO
interface muldiv_seq_if #(
    parameter int unsigned DATA_W = 32
);
    logic              start;
    logic [1:0]        op;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;
    logic              flush;
    logic              hi_we;
    logic              lo_we;
    logic [DATA_W-1:0] wdata;
    logic              busy;
    logic              done;
    logic              div_zero;
    logic              op_err;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;

    modport master (
        output start, op, rs_val, rt_val, flush, hi_we, lo_we, wdata,
        input  busy, done, div_zero, op_err, hi, lo
    );

    modport slave (
        input  start, op, rs_val, rt_val, flush, hi_we, lo_we, wdata,
        output busy, done, div_zero, op_err, hi, lo
    );
endinterface

// File: rtl/muldiv_seq.sv
// muldiv_seq -- multi-cycle MULT/MULTU/DIV/DIVU sequencer with HI/LO pair.
//
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : muldiv_seq_if.slave (start/op/operands/flush/MTHI/MTLO in,
//          busy/done/div_zero/op_err/hi/lo out)
//
// Sequence: IDLE -> PREP -> RUN (DATA_W steps) -> FIX -> DONE -> IDLE.
// One 33-bit add/sub datapath (op 00 add, 01 sub) is shared by the
// shift-add multiply and the restoring divide. Signed operations run on
// magnitudes; signs are reapplied in FIX.
//
// Build option: define MULDIV_DIV_EN to include divide support. Without
// it, DIV/DIVU requests are rejected with a one-cycle op_err pulse and
// div_zero stays 0.
module muldiv_seq #(
    parameter int unsigned DATA_W = 32
) (
    input  logic         clk,
    input  logic         rst,
    muldiv_seq_if.slave  bus
);

`ifdef MULDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    localparam int unsigned CNT_W = $clog2(DATA_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_RUN,
        S_FIX,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [1:0]          op_q, op_d;
    logic [DATA_W:0]     acc_q, acc_d;       // product upper / remainder
    logic [DATA_W-1:0]   quo_q, quo_d;       // multiplier-product lower / quotient
    logic [DATA_W-1:0]   mc_q, mc_d;         // multiplicand / divisor
    logic                neg_quo_q, neg_quo_d;
    logic                neg_rem_q, neg_rem_d;
    logic                dz_q, dz_d;         // divisor was zero
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                div_zero_q, div_zero_d;
    logic                op_err_q, op_err_d;
    logic [DATA_W-1:0]   hi_q, hi_d;
    logic [DATA_W-1:0]   lo_q, lo_d;

    // Shared 33-bit add/sub datapath
    logic [1:0]          alu_op;
    logic [DATA_W:0]     alu_a, alu_b, alu_y;

    always_comb begin
        case (alu_op)
            2'b01:   alu_y = alu_a - alu_b;
            default: alu_y = alu_a + alu_b;
        endcase
    end

    // One RUN iteration
    logic [DATA_W:0]     mul_tmp;
    logic [DATA_W:0]     step_acc;
    logic [DATA_W-1:0]   step_quo;

    always_comb begin
        alu_op   = 2'b00;
        alu_a    = acc_q;
        alu_b    = {1'b0, mc_q};
        mul_tmp  = quo_q[0] ? alu_y : acc_q;
        step_acc = {1'b0, mul_tmp[DATA_W:1]};
        step_quo = {mul_tmp[0], quo_q[DATA_W-1:1]};
        if (DIV_EN && op_q[1]) begin
            // Shift {rem, quot} left, then trial-subtract the divisor; a
            // clear sign bit means the subtraction fits.
            alu_op = 2'b01;
            alu_a  = {acc_q[DATA_W-1:0], quo_q[DATA_W-1]};
            if (!alu_y[DATA_W]) begin
                step_acc = alu_y;
                step_quo = {quo_q[DATA_W-2:0], 1'b1};
            end else begin
                step_acc = alu_a;
                step_quo = {quo_q[DATA_W-2:0], 1'b0};
            end
        end
    end

    // Sign fix-up and result selection for FIX
    logic [2*DATA_W-1:0] prod, prod_fix;
    logic [DATA_W-1:0]   quo_fix, rem_fix;
    logic [DATA_W-1:0]   res_hi, res_lo;

    always_comb begin
        prod     = {acc_q[DATA_W-1:0], quo_q};
        prod_fix = neg_quo_q ? ('0 - prod) : prod;
        quo_fix  = neg_quo_q ? ('0 - quo_q) : quo_q;
        rem_fix  = neg_rem_q ? ('0 - acc_q[DATA_W-1:0]) : acc_q[DATA_W-1:0];
        // Divide by zero: the natural remainder already equals the original
        // dividend once its sign is restored; only the quotient is forced.
        if (dz_q) begin
            quo_fix = '1;
        end
        if (DIV_EN && op_q[1]) begin
            res_hi = rem_fix;
            res_lo = quo_fix;
        end else begin
            res_hi = prod_fix[2*DATA_W-1:DATA_W];
            res_lo = prod_fix[DATA_W-1:0];
        end
    end

    // Next-state logic
    logic accept, reject, is_signed;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        acc_d      = acc_q;
        quo_d      = quo_q;
        mc_d       = mc_q;
        neg_quo_d  = neg_quo_q;
        neg_rem_d  = neg_rem_q;
        dz_d       = dz_q;
        div_zero_d = div_zero_q;
        op_err_d   = 1'b0;
        hi_d       = hi_q;
        lo_d       = lo_q;
        accept     = 1'b0;
        reject     = 1'b0;
        is_signed  = ~op_q[0];

        if ((state_q == S_IDLE || state_q == S_DONE) && bus.start) begin
            if (bus.op[1] && !DIV_EN) begin
                reject = 1'b1;
            end else begin
                accept = 1'b1;
            end
        end

        if (!busy_q) begin
            if (bus.hi_we) hi_d = bus.wdata;
            if (bus.lo_we) lo_d = bus.wdata;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (accept) begin
                    state_d    = S_PREP;
                    op_d       = bus.op;
                    div_zero_d = 1'b0;
                    // quo holds the value that shifts (multiplier or
                    // dividend), mc the value that is added/subtracted.
                    if (bus.op[1]) begin
                        quo_d = bus.rs_val;
                        mc_d  = bus.rt_val;
                    end else begin
                        quo_d = bus.rt_val;
                        mc_d  = bus.rs_val;
                    end
                end
                if (reject) begin
                    op_err_d = 1'b1;
                end
            end
            S_PREP: begin
                neg_quo_d = is_signed & (quo_q[DATA_W-1] ^ mc_q[DATA_W-1]);
                neg_rem_d = is_signed & (op_q[1] ? quo_q[DATA_W-1] : mc_q[DATA_W-1]);
                if (is_signed && quo_q[DATA_W-1]) quo_d = '0 - quo_q;
                if (is_signed && mc_q[DATA_W-1])  mc_d  = '0 - mc_q;
                dz_d    = DIV_EN & op_q[1] & (mc_q == '0);
                acc_d   = '0;
                cnt_d   = CNT_W'(DATA_W - 1);
                state_d = S_RUN;
            end
            S_RUN: begin
                acc_d = step_acc;
                quo_d = step_quo;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                hi_d    = res_hi;
                lo_d    = res_lo;
                state_d = S_DONE;
                if (DIV_EN && op_q[1] && dz_q) begin
                    div_zero_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A flush abandons the operation before FIX can commit anything.
        if (bus.flush && (state_q inside {S_PREP, S_RUN, S_FIX})) begin
            state_d    = S_IDLE;
            hi_d       = hi_q;
            lo_d       = lo_q;
            div_zero_d = div_zero_q;
        end

        busy_d = (state_d inside {S_PREP, S_RUN, S_FIX});
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            op_q       <= '0;
            acc_q      <= '0;
            quo_q      <= '0;
            mc_q       <= '0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            dz_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            op_err_q   <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            acc_q      <= acc_d;
            quo_q      <= quo_d;
            mc_q       <= mc_d;
            neg_quo_q  <= neg_quo_d;
            neg_rem_q  <= neg_rem_d;
            dz_q       <= dz_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
            op_err_q   <= op_err_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.div_zero = div_zero_q;
    assign bus.op_err   = op_err_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq -- directed, table-driven bench for muldiv_seq.
// Divide vectors are included when MULDIV_DIV_EN is defined; otherwise the
// bench checks that divide requests are rejected.
module tb_muldiv_seq;

    localparam int unsigned W = 32;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    logic clk = 1'b0;
    logic rst;

    muldiv_seq_if #(.DATA_W(W)) bus ();

    muldiv_seq #(.DATA_W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [31:0] hi, input logic [31:0] lo, input logic dz);
        vec_t v;
        v.op = op; v.rs = rs; v.rt = rt; v.hi = hi; v.lo = lo; v.dz = dz;
        vecs.push_back(v);
    endtask

    // Drive a request; returns at the negedge of cycle 1 with start low.
    task automatic start_op(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt);
        bus.start  = 1'b1;
        bus.op     = op;
        bus.rs_val = rs;
        bus.rt_val = rt;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Called at the negedge of cycle cyc0; returns at the negedge where done is seen.
    task automatic wait_done(input int cyc0, input string tag);
        int cyc;
        int busy_cnt;
        cyc = cyc0;
        busy_cnt = 0;
        while (bus.done !== 1'b1 && cyc < 80) begin
            if (bus.busy === 1'b1) busy_cnt++;
            @(negedge clk);
            cyc++;
        end
        check({tag, " latency"}, 64'(cyc), 64'd35);
        check({tag, " busy cycles"}, 64'(busy_cnt), 64'(35 - cyc0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] h_val;
        logic [31:0] l_val;
        int          done_seen;

        h_val = 32'h1111_2222;
        l_val = 32'h3333_4444;

        add(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        add(OP_MULT,  32'hFFFF_FFF9, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        add(OP_MULT,  32'h0000_0003, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        add(OP_MULT,  32'h0000_0002, 32'h0000_0002, 32'h0000_0000, 32'h0000_0004, 1'b0);
        add(OP_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 1'b0);
        add(OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0);
        add(OP_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0);
        add(OP_MULT,  32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0001, 1'b0);
        add(OP_MULTU, 32'hDEAD_BEEF, 32'h0000_0002, 32'h0000_0001, 32'hBD5B_7DDE, 1'b0);
        add(OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0);
        add(OP_MULT,  32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
        add(OP_MULTU, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0);
`ifdef MULDIV_DIV_EN
        add(OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        add(OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        1'b0);
        add(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
        add(OP_DIVU,  32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF, 1'b1);
        add(OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
        add(OP_DIV,   32'hFFFF_FFF8, 32'h0000_0000, 32'hFFFF_FFF8, 32'hFFFF_FFFF, 1'b1);
        add(OP_DIVU,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0);
        add(OP_DIVU,  32'h0000_0005, 32'h0000_000A, 32'h0000_0005, 32'h0000_0000, 1'b0);
        add(OP_DIVU,  32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001, 32'h7FFF_FFFC, 1'b0);
`endif

        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.op     = 2'b00;
        bus.rs_val = '0;
        bus.rt_val = '0;
        bus.flush  = 1'b0;
        bus.hi_we  = 1'b0;
        bus.lo_we  = 1'b0;
        bus.wdata  = '0;

        repeat (2) @(negedge clk);
        check("reset status {busy,done,div_zero,op_err}",
              64'({bus.busy, bus.done, bus.div_zero, bus.op_err}), 64'd0);
        check("reset hi/lo", {bus.hi, bus.lo}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Table-driven operations
        foreach (vecs[i]) begin
            start_op(vecs[i].op, vecs[i].rs, vecs[i].rt);
            check($sformatf("vec%0d busy in cycle 1", i), 64'(bus.busy), 64'd1);
            wait_done(1, $sformatf("vec%0d", i));
            check($sformatf("vec%0d hi", i), 64'(bus.hi), 64'(vecs[i].hi));
            check($sformatf("vec%0d lo", i), 64'(bus.lo), 64'(vecs[i].lo));
            check($sformatf("vec%0d div_zero", i), 64'(bus.div_zero), 64'(vecs[i].dz));
            @(negedge clk);
            check($sformatf("vec%0d done one pulse", i), 64'(bus.done), 64'd0);
        end

        // Back-to-back: second start issued while in DONE
        start_op(OP_MULT, 32'hFFFF_FFF9, 32'h0000_0003);
        wait_done(1, "b2b first");
        check("b2b first hi/lo", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        start_op(OP_MULT, 32'h0000_0002, 32'h0000_0002);
        check("b2b second busy in cycle 1", 64'(bus.busy), 64'd1);
        wait_done(1, "b2b second");
        check("b2b second hi/lo", {bus.hi, bus.lo}, 64'h0000_0000_0000_0004);
        @(negedge clk);

`ifdef MULDIV_DIV_EN
        // div_zero persists until the next accepted start
        start_op(OP_DIVU, 32'h0000_1234, 32'h0000_0000);
        wait_done(1, "dz set");
        check("dz set flag", 64'(bus.div_zero), 64'd1);
        @(negedge clk);
        check("dz held in idle", 64'(bus.div_zero), 64'd1);
        start_op(OP_DIVU, 32'd100, 32'd7);
        check("dz cleared by start", 64'(bus.div_zero), 64'd0);
        check("div op_err stays low", 64'(bus.op_err), 64'd0);
        wait_done(1, "dz clear op");
        check("dz clear op hi/lo", {bus.hi, bus.lo}, {32'd2, 32'd14});
        @(negedge clk);
`endif

        // MTHI / MTLO while idle
        bus.hi_we = 1'b1;
        bus.wdata = h_val;
        @(negedge clk);
        bus.hi_we = 1'b0;
        check("mthi idle", 64'(bus.hi), 64'(h_val));
        bus.lo_we = 1'b1;
        bus.wdata = l_val;
        @(negedge clk);
        bus.lo_we = 1'b0;
        check("mtlo idle", 64'(bus.lo), 64'(l_val));

        // Flush at cycle 10 of a MULT
        start_op(OP_MULT, 32'd5, 32'd6);
        repeat (9) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush busy low next cycle", 64'(bus.busy), 64'd0);
        check("flush hi/lo kept", {bus.hi, bus.lo}, {h_val, l_val});
        done_seen = 0;
        repeat (40) begin
            if (bus.done === 1'b1) done_seen++;
            @(negedge clk);
        end
        check("flush no done", 64'(done_seen), 64'd0);
        check("flush hi/lo still kept", {bus.hi, bus.lo}, {h_val, l_val});

        // MTLO while busy is dropped, then applied once idle
        start_op(OP_MULTU, 32'd3, 32'd5);
        repeat (4) @(negedge clk);
        bus.lo_we = 1'b1;
        bus.wdata = 32'hA5A5_A5A5;
        @(negedge clk);
        bus.lo_we = 1'b0;
        check("mtlo busy dropped", 64'(bus.lo), 64'(l_val));
        wait_done(6, "mtlo busy op");
        check("mtlo busy op hi/lo", {bus.hi, bus.lo}, 64'd15);
        @(negedge clk);
        bus.lo_we = 1'b1;
        bus.wdata = 32'hA5A5_A5A5;
        @(negedge clk);
        bus.lo_we = 1'b0;
        check("mtlo idle after op", 64'(bus.lo), 64'hA5A5_A5A5);

`ifndef MULDIV_DIV_EN
        // Divide requests rejected without divide hardware
        bus.start  = 1'b1;
        bus.op     = OP_DIV;
        bus.rs_val = 32'd10;
        bus.rt_val = 32'd3;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        check("div reject op_err pulse", 64'(bus.op_err), 64'd1);
        check("div reject busy low", 64'(bus.busy), 64'd0);
        check("div reject hi/lo unchanged", {bus.hi, bus.lo}, 64'h0000_0000_A5A5_A5A5);
        @(negedge clk);
        check("div reject op_err one cycle", 64'(bus.op_err), 64'd0);
        check("div reject no done", 64'(bus.done), 64'd0);
        bus.start  = 1'b1;
        bus.op     = OP_DIVU;
        bus.rs_val = 32'h0000_1234;
        bus.rt_val = 32'h0000_0000;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        check("divu reject op_err", 64'(bus.op_err), 64'd1);
        repeat (40) @(negedge clk);
        check("divu reject div_zero tied low", 64'(bus.div_zero), 64'd0);
        check("divu reject still idle", 64'({bus.busy, bus.done}), 64'd0);
`endif

        // Set nonzero HI so the asynchronous reset is observable
        bus.hi_we = 1'b1;
        bus.wdata = h_val;
        @(negedge clk);
        bus.hi_we = 1'b0;

        // Asynchronous reset mid-RUN
        start_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (19) @(negedge clk);
        check("pre-reset busy", 64'(bus.busy), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async reset status", 64'({bus.busy, bus.done, bus.div_zero, bus.op_err}), 64'd0);
        check("async reset hi/lo", {bus.hi, bus.lo}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("post-reset idle", 64'({bus.busy, bus.done}), 64'd0);

        // Operation after reset still works
        start_op(OP_MULT, 32'hFFFF_FFF9, 32'h0000_0003);
        wait_done(1, "post-reset op");
        check("post-reset op hi/lo", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
